// File: rtl/vpu_seq.sv
// vpu_seq: vector sequencer streaming operand pairs through the ALU at one element per cycle.
// Two-stage pipeline: read issue -> ALU operand stage -> registered write-back.
module vpu_seq #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_opcode,
    input  logic [ADDR_W-1:0] cmd_src0,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              stall,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    input  logic [DATA_W-1:0] rd_data0,
    input  logic [DATA_W-1:0] rd_data1,
    output logic              alu_start,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_operand0,
    output logic [DATA_W-1:0] alu_operand1,
    input  logic [DATA_W-1:0] alu_result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state_q, state_d;
    logic [OP_W-1:0]   opc_q;
    logic [ADDR_W-1:0] src0_q, src1_q, dst_q, a1_q, wa_q;
    logic [LEN_W-1:0]  len_q, idx_q, idx_d;
    logic [DATA_W-1:0] wd_q;
    logic              s1_q, wv_q, accept, last, bad_cmd;

    assign cmd_ready = state_q == IDLE;
    assign busy      = !cmd_ready;
    assign accept    = cmd_valid && cmd_ready;
    assign bad_cmd   = cmd_len == '0 || cmd_opcode > OP_W'(2);
    assign rd_en     = state_q == RUN && !stall;
    assign last      = LEN_W'(idx_q + 1'b1) == len_q;
    assign rd_addr0  = rd_en ? src0_q + ADDR_W'(idx_q) : '0;
    assign rd_addr1  = rd_en ? src1_q + ADDR_W'(idx_q) : '0;
    assign alu_start    = s1_q;
    assign alu_opcode   = opc_q;
    assign alu_operand0 = s1_q ? rd_data0 : '0;
    assign alu_operand1 = s1_q ? rd_data1 : '0;
    assign wr_en   = wv_q;
    assign wr_addr = wa_q;
    assign wr_data = wd_q;
    assign done    = state_q == DONE;
    assign err     = done && opc_q > OP_W'(2);
    assign idx_d   = accept ? '0 : rd_en ? idx_q + 1'b1 : idx_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  state_d = accept ? (bad_cmd ? DONE : RUN) : IDLE;
            RUN:   state_d = (rd_en && last) ? DRAIN : RUN;
            // the final element leaves the ALU stage one cycle before its write fires
            DRAIN: state_d = s1_q ? DRAIN : DONE;
            DONE:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opc_q   <= '0;
            src0_q  <= '0;
            src1_q  <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            s1_q    <= 1'b0;
            a1_q    <= '0;
            wv_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                opc_q  <= cmd_opcode;
                src0_q <= cmd_src0;
                src1_q <= cmd_src1;
                dst_q  <= cmd_dst;
                len_q  <= cmd_len;
            end
            s1_q <= rd_en;
            a1_q <= rd_en ? dst_q + ADDR_W'(idx_q) : '0;
            wv_q <= s1_q;
            wa_q <= s1_q ? a1_q : '0;
            wd_q <= s1_q ? alu_result : '0;
        end
    end
endmodule

// File: tb/tb_vpu_seq.sv
// tb_vpu_seq: directed scoreboard bench for vpu_seq with SRAM and ALU stand-ins.
module tb_vpu_seq;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, stall = 1'b0;
    logic [3:0]  cmd_opcode = '0;
    logic [9:0]  cmd_src0 = '0, cmd_src1 = '0, cmd_dst = '0;
    logic [10:0] cmd_len = '0;
    logic        rd_en, alu_start, wr_en, busy, done, err;
    logic [9:0]  rd_addr0, rd_addr1, wr_addr;
    logic [31:0] rd_data0 = '0, rd_data1 = '0, alu_operand0, alu_operand1, alu_result, wr_data;
    logic [3:0]  alu_opcode;
    logic [31:0] mem0 [1024];
    logic [31:0] mem1 [1024];

    typedef struct {int cyc; logic [9:0] addr; logic [31:0] data;} wexp_t;
    typedef struct {int cyc; logic err; int n;} dexp_t;
    wexp_t wq[$];
    dexp_t dq[$];
    wexp_t we;
    dexp_t de;
    int cyc = 0, checks = 0, failures = 0, nrd = 0, nalu = 0, nwr = 0, a;

    vpu_seq dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_src0(cmd_src0), .cmd_src1(cmd_src1), .cmd_dst(cmd_dst),
        .cmd_len(cmd_len), .stall(stall), .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .rd_data0(rd_data0), .rd_data1(rd_data1), .alu_start(alu_start), .alu_opcode(alu_opcode),
        .alu_operand0(alu_operand0), .alu_operand1(alu_operand1), .alu_result(alu_result),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM stand-in: data valid one cycle after rd_en
    always @(posedge clk) begin
        rd_data0 <= rd_en ? mem0[rd_addr0] : '0;
        rd_data1 <= rd_en ? mem1[rd_addr1] : '0;
    end

    assign alu_result = alu_opcode == 4'd0 ? alu_operand0 + alu_operand1 :
                        alu_opcode == 4'd1 ? alu_operand0 - alu_operand1 :
                        alu_opcode == 4'd2 ? alu_operand0 * alu_operand1 : 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic issue(input logic [3:0] op, input logic [9:0] s0, input logic [9:0] s1,
                         input logic [9:0] d, input logic [10:0] n, output int acc);
        int t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) flag("issue_timeout");
        cmd_opcode = op; cmd_src0 = s0; cmd_src1 = s1; cmd_dst = d; cmd_len = n;
        cmd_valid = 1'b1;
        acc = cyc;
    endtask

    task automatic release_cmd();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic expw(input int c, input logic [9:0] ad, input logic [31:0] dt);
        wq.push_back('{c, ad, dt});
    endtask

    task automatic expd(input int c, input logic e, input int n);
        dq.push_back('{c, e, n});
    endtask

    // monitor: samples mid-cycle after stimulus has settled
    initial forever begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            nrd = 0; nalu = 0; nwr = 0;
        end else begin
            chk("busy", busy, !cmd_ready);
            if (rd_en) nrd++;
            if (alu_start) nalu++;
            else chk("alu_idle", {alu_operand0, alu_operand1}, 64'd0);
            if (wr_en) begin
                nwr++;
                if (wq.size() == 0) flag("wr_unexpected");
                else begin
                    we = wq.pop_front();
                    chk("wr_cyc", cyc, we.cyc);
                    chk("wr_addr", wr_addr, we.addr);
                    chk("wr_data", wr_data, we.data);
                end
            end else chk("wr_idle", {wr_addr, wr_data}, 64'd0);
            if (done) begin
                if (dq.size() == 0) flag("done_unexpected");
                else begin
                    de = dq.pop_front();
                    chk("done_cyc", cyc, de.cyc);
                    chk("done_err", err, de.err);
                    chk("rd_count", nrd, de.n);
                    chk("alu_count", nalu, de.n);
                    chk("wr_count", nwr, de.n);
                end
                nrd = 0; nalu = 0; nwr = 0;
            end else chk("err_idle", err, 1'b0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        for (int k = 0; k < 4; k++) begin
            mem0[k] = k + 1;
            mem1['h010 + k] = 10 * (k + 1);
        end
        mem1['h020] = 1;
        mem0['h030] = 3; mem1['h030] = 32'h5555_5556;
        for (int k = 0; k < 6; k++) begin
            mem0['h040 + k] = k + 1;
            mem1['h040 + k] = 7;
        end
        mem0[1022] = 100; mem0[1023] = 200;
        mem1['h300] = 5; mem1['h301] = 6; mem1['h302] = 7;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_strobes", {busy, done, err, rd_en, alu_start, wr_en}, 6'd0);
        chk("rst_addr", {rd_addr0, rd_addr1, wr_addr, alu_opcode}, 34'd0);
        chk("rst_data", {wr_data, alu_operand0}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(4'd0, 10'h000, 10'h010, 10'h100, 11'd4, a);
        for (int k = 0; k < 4; k++) expw(a + 3 + k, 10'h100 + 10'(k), 32'(11 * (k + 1)));
        expd(a + 7, 1'b0, 4);
        release_cmd();

        issue(4'd1, 10'h020, 10'h020, 10'h200, 11'd1, a);
        expw(a + 3, 10'h200, 32'hFFFF_FFFF);
        expd(a + 4, 1'b0, 1);
        release_cmd();

        issue(4'd2, 10'h030, 10'h030, 10'h210, 11'd1, a);
        expw(a + 3, 10'h210, 32'h0000_0002);
        expd(a + 4, 1'b0, 1);
        release_cmd();

        issue(4'd2, 10'h040, 10'h040, 10'h220, 11'd6, a);
        expw(a + 3, 10'h220, 7);
        expw(a + 4, 10'h221, 14);
        for (int k = 2; k < 6; k++) expw(a + 5 + k, 10'h220 + 10'(k), 32'(7 * (k + 1)));
        expd(a + 11, 1'b0, 6);
        release_cmd();
        @(negedge clk);
        @(negedge clk);
        stall = 1'b1;
        repeat (2) @(negedge clk);
        stall = 1'b0;

        issue(4'd0, 10'h000, 10'h010, 10'h230, 11'd0, a);
        expd(a + 1, 1'b0, 0);
        release_cmd();

        issue(4'd5, 10'h000, 10'h010, 10'h240, 11'd8, a);
        expd(a + 1, 1'b1, 0);
        release_cmd();

        issue(4'd0, 10'd1022, 10'h300, 10'd1023, 11'd3, a);
        expw(a + 3, 10'd1023, 105);
        expw(a + 4, 10'd0, 206);
        expw(a + 5, 10'd1, 8);
        expd(a + 6, 1'b0, 3);
        release_cmd();

        issue(4'd0, 10'h000, 10'h010, 10'h140, 11'd8, a);
        release_cmd();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_strobes", {busy, done, rd_en, alu_start, wr_en}, 5'd0);
        chk("midrst_ready", cmd_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        issue(4'd0, 10'h000, 10'h010, 10'h180, 11'd4, a);
        for (int k = 0; k < 4; k++) expw(a + 3 + k, 10'h180 + 10'(k), 32'(11 * (k + 1)));
        expd(a + 7, 1'b0, 4);
        release_cmd();

        for (int t = 0; t < 200 && dq.size() != 0; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("wq_empty", wq.size(), 0);
        chk("dq_empty", dq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
